// File: rtl/nonzero_serializer_pkg.sv
// Shared types and constants for the nonzero serializer.
package nonzero_serializer_pkg;

  // Run control: RUN accepts groups, DRAIN finishes the last loaded group.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

  localparam int FIFO_DEPTH     = 4;
  localparam int FIFO_LOG_DEPTH = 2;

endpackage

// File: rtl/nonzero_serializer_fifo.sv
// Small synchronous FIFO; read data is the head entry, visible combinationally.
module nonzero_serializer_fifo #(
  parameter int WIDTH     = 8,
  parameter int DEPTH     = 4,
  parameter int LOG_DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             empty,
  output logic             full,
  output logic             almost_full
);

  localparam logic [LOG_DEPTH-1:0] PTR_ONE  = (LOG_DEPTH)'(1);
  localparam logic [LOG_DEPTH:0]   CNT_ONE  = (LOG_DEPTH+1)'(1);
  localparam logic [LOG_DEPTH:0]   CNT_FULL = (LOG_DEPTH+1)'(DEPTH);
  localparam logic [LOG_DEPTH:0]   CNT_AF   = (LOG_DEPTH+1)'(DEPTH-1);

  logic [WIDTH-1:0]     mem [DEPTH];
  logic [LOG_DEPTH-1:0] rd_ptr, wr_ptr;
  logic [LOG_DEPTH:0]   count_r;
  logic                 do_push, do_pop;

  assign empty       = (count_r == '0);
  assign full        = (count_r == CNT_FULL);
  assign almost_full = (count_r >= CNT_AF);
  assign rdata       = mem[rd_ptr];

  // A push into a full FIFO is only taken when a pop frees a slot the same cycle.
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);

  // Pointer and occupancy tracking.
  always_ff @(posedge clk) begin
    if (!rst) begin
      rd_ptr  <= '0;
      wr_ptr  <= '0;
      count_r <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
      if (do_pop)  rd_ptr <= rd_ptr + PTR_ONE;
      case ({do_push, do_pop})
        2'b10:   count_r <= count_r + CNT_ONE;
        2'b01:   count_r <= count_r - CNT_ONE;
        default: count_r <= count_r;
      endcase
    end
  end

  // Storage write; contents need no reset since occupancy gates reads.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/nonzero_serializer_lsb_priority_encoder.sv
// Index of the lowest set bit plus an any-set flag.
module lsb_priority_encoder #(
  parameter int WIDTH     = 4,
  parameter int LOG_WIDTH = 2
) (
  input  logic [WIDTH-1:0]     bits,
  output logic [LOG_WIDTH-1:0] idx,
  output logic                 any
);

  // Scan from the top down so the lowest set bit is the final winner.
  always_comb begin
    idx = '0;
    for (int i = WIDTH - 1; i >= 0; i--) begin
      if (bits[i]) idx = (LOG_WIDTH)'(i);
    end
    any = |bits;
  end

endmodule

// File: rtl/nonzero_serializer.sv
// Serializes the nonzero elements of zero-flagged groups, one per cycle,
// under the same iteration-count control as the upstream detector.
import nonzero_serializer_pkg::*;

module nonzero_serializer #(
  parameter int GROUP_SIZE             = 4,
  parameter int LOG_GROUP_SIZE         = 2,
  parameter int DATA_WIDTH             = 8,
  parameter int LOG_MAX_ITERS          = 16,
  parameter int LOG_MAX_READS_PER_ITER = 16
) (
  input  logic                                        clk,
  input  logic                                        rst,
  input  logic                                        configure,
  input  logic [LOG_MAX_ITERS-1:0]                    num_iters,
  input  logic [LOG_MAX_READS_PER_ITER-1:0]           num_reads_per_iter,
  input  logic [GROUP_SIZE*DATA_WIDTH+GROUP_SIZE-1:0] data_in,
  input  logic                                        valid_in,
  output logic                                        avail_out,
  output logic [DATA_WIDTH-1:0]                       data_out,
  output logic [LOG_GROUP_SIZE-1:0]                   index_out,
  output logic                                        last_out,
  output logic                                        valid_out,
  input  logic                                        avail_in,
  output logic                                        done_out
);

  localparam int EW = GROUP_SIZE * DATA_WIDTH;
  localparam int W  = EW + GROUP_SIZE;

  localparam logic [LOG_MAX_ITERS-1:0]          ITER_ONE = (LOG_MAX_ITERS)'(1);
  localparam logic [LOG_MAX_READS_PER_ITER-1:0] READ_ONE = (LOG_MAX_READS_PER_ITER)'(1);
  localparam logic [GROUP_SIZE-1:0]             BIT_ONE  = (GROUP_SIZE)'(1);

  state_t                            st_r, st_nx;
  logic [LOG_MAX_ITERS-1:0]          iters_r;
  logic [LOG_MAX_READS_PER_ITER-1:0] reads_r, reads_copy_r;
  logic [EW-1:0]                     data_r;
  logic [GROUP_SIZE-1:0]             pend_r;

  logic [W-1:0]              head;
  logic                      empty, full, almost_full;
  logic [LOG_GROUP_SIZE-1:0] idx;
  logic                      any, single, emit, last_emit, load, final_load, cfg_zero;

  nonzero_serializer_fifo #(
    .WIDTH    (W),
    .DEPTH    (FIFO_DEPTH),
    .LOG_DEPTH(FIFO_LOG_DEPTH)
  ) u_fifo (
    .clk        (clk),
    .rst        (rst),
    .push       (valid_in),
    .pop        (load),
    .wdata      (data_in),
    .rdata      (head),
    .empty      (empty),
    .full       (full),
    .almost_full(almost_full)
  );

  lsb_priority_encoder #(
    .WIDTH    (GROUP_SIZE),
    .LOG_WIDTH(LOG_GROUP_SIZE)
  ) u_enc (
    .bits(pend_r),
    .idx (idx),
    .any (any)
  );

  assign avail_out  = ~almost_full & ~full;
  assign single     = ((pend_r & (pend_r - BIT_ONE)) == '0);
  assign emit       = any & avail_in;
  assign last_emit  = emit & single;
  assign cfg_zero   = (num_iters == '0) || (num_reads_per_iter == '0);
  // A load overlaps the final emit of the previous group so groups stream without a bubble.
  assign load       = (st_r == ST_RUN) & ~configure & ~empty & (~any | last_emit);
  assign final_load = load & (reads_r == READ_ONE) & (iters_r == ITER_ONE);

  // Output element is the lowest still-pending one; zeroed when nothing is emitted.
  always_comb begin
    valid_out = emit;
    data_out  = '0;
    index_out = '0;
    last_out  = 1'b0;
    if (emit) begin
      data_out  = data_r[idx*DATA_WIDTH +: DATA_WIDTH];
      index_out = idx;
      last_out  = single;
    end
  end

  // Run-control state register.
  always_ff @(posedge clk) begin
    if (!rst) st_r <= ST_IDLE;
    else      st_r <= st_nx;
  end

  // Next state and end-of-run pulse; configure overrides everything.
  always_comb begin
    st_nx    = st_r;
    done_out = 1'b0;
    unique case (st_r)
      ST_IDLE:  st_nx = ST_IDLE;
      ST_RUN:   if (final_load) st_nx = ST_DRAIN;
      ST_DRAIN: if (!any) begin
        done_out = 1'b1;
        st_nx    = ST_IDLE;
      end
      default:  st_nx = ST_IDLE;
    endcase
    if (configure) st_nx = cfg_zero ? ST_IDLE : ST_RUN;
  end

  // Group register, pending mask and iteration counters.
  always_ff @(posedge clk) begin
    if (!rst) begin
      iters_r      <= '0;
      reads_r      <= '0;
      reads_copy_r <= '0;
      data_r       <= '0;
      pend_r       <= '0;
    end else if (configure) begin
      iters_r      <= num_iters;
      reads_r      <= num_reads_per_iter;
      reads_copy_r <= num_reads_per_iter;
      pend_r       <= '0;
    end else if (load) begin
      data_r <= head[EW-1:0];
      pend_r <= ~head[W-1 -: GROUP_SIZE];
      if (reads_r == READ_ONE) begin
        if (iters_r != ITER_ONE) begin
          iters_r <= iters_r - ITER_ONE;
          reads_r <= reads_copy_r;
        end
      end else begin
        reads_r <= reads_r - READ_ONE;
      end
    end else if (emit) begin
      pend_r <= pend_r & ~(BIT_ONE << idx);
    end
  end

endmodule

// File: tb/tb_nonzero_serializer.sv
// Bench for nonzero_serializer: a queue-based model predicts every output each
// cycle, plus literal checks on the directed scenarios.
module tb_nonzero_serializer;

  localparam int G  = 4;
  localparam int LG = 2;
  localparam int DW = 8;
  localparam int LI = 16;
  localparam int LR = 16;
  localparam int EW = G * DW;
  localparam int W  = EW + G;

  logic          clk, rst, configure, valid_in, avail_in;
  logic [LI-1:0] num_iters;
  logic [LR-1:0] num_reads_per_iter;
  logic [W-1:0]  data_in;
  logic          avail_out, last_out, valid_out, done_out;
  logic [DW-1:0] data_out;
  logic [LG-1:0] index_out;

  nonzero_serializer #(
    .GROUP_SIZE(G), .LOG_GROUP_SIZE(LG), .DATA_WIDTH(DW),
    .LOG_MAX_ITERS(LI), .LOG_MAX_READS_PER_ITER(LR)
  ) dut (
    .clk(clk), .rst(rst), .configure(configure), .num_iters(num_iters),
    .num_reads_per_iter(num_reads_per_iter), .data_in(data_in), .valid_in(valid_in),
    .avail_out(avail_out), .data_out(data_out), .index_out(index_out),
    .last_out(last_out), .valid_out(valid_out), .avail_in(avail_in), .done_out(done_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  bit chk_en = 1'b0;

  // Observed emissions and end-of-run pulses.
  logic [DW-1:0] log_d[$];
  int            log_i[$];
  bit            log_l[$];
  int            log_t[$];
  int            done_cnt = 0;
  int            done_t = 0;

  // Model: FIFO of words, list of pending nonzero elements, groups left in run.
  logic [W-1:0]  m_fifo[$];
  logic [DW-1:0] m_pd[$];
  logic [LG-1:0] m_pi[$];
  longint        m_left = 0;
  bit            m_busy = 1'b0;

  logic          e_valid, e_last, e_done, e_avail, m_load;
  logic [DW-1:0] e_data;
  logic [LG-1:0] e_idx;
  logic [W-1:0]  m_w;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Per-cycle compare against the model, then advance the model across the next edge.
  always @(negedge clk) begin
    e_valid = (m_pd.size() > 0) && avail_in;
    e_data  = e_valid ? m_pd[0] : '0;
    e_idx   = e_valid ? m_pi[0] : '0;
    e_last  = e_valid && (m_pd.size() == 1);
    e_done  = m_busy && (m_left == 0) && (m_pd.size() == 0);
    e_avail = (m_fifo.size() < 3);
    if (chk_en) begin
      n_cmp++;
      if ({valid_out, data_out, index_out, last_out, done_out, avail_out} !==
          {e_valid, e_data, e_idx, e_last, e_done, e_avail}) begin
        n_bad++;
        $display("FAIL cycle %0d outputs: got v=%0b d=%0h i=%0d l=%0b done=%0b av=%0b expected v=%0b d=%0h i=%0d l=%0b done=%0b av=%0b",
                 cyc, valid_out, data_out, index_out, last_out, done_out, avail_out,
                 e_valid, e_data, e_idx, e_last, e_done, e_avail);
      end
      if (valid_out) begin
        log_d.push_back(data_out);
        log_i.push_back(int'(index_out));
        log_l.push_back(last_out);
        log_t.push_back(cyc);
      end
      if (done_out) begin
        done_cnt++;
        done_t = cyc;
      end
    end
    if (!rst) begin
      m_fifo.delete(); m_pd.delete(); m_pi.delete();
      m_left = 0; m_busy = 1'b0;
    end else begin
      m_load = (m_left > 0) && (m_fifo.size() > 0) &&
               ((m_pd.size() == 0) || (e_valid && m_pd.size() == 1));
      if (configure) begin
        m_pd.delete(); m_pi.delete();
        m_left = longint'(num_iters) * longint'(num_reads_per_iter);
        m_busy = (m_left != 0);
      end else begin
        if (e_done) m_busy = 1'b0;
        if (e_valid) begin
          void'(m_pd.pop_front());
          void'(m_pi.pop_front());
        end
        if (m_load) begin
          m_w = m_fifo.pop_front();
          for (int i = 0; i < G; i++)
            if (m_w[EW+i] == 1'b0) begin
              m_pd.push_back(m_w[i*DW +: DW]);
              m_pi.push_back(LG'(i));
            end
          m_left--;
        end
      end
      if (valid_in && m_fifo.size() < 4) m_fifo.push_back(data_in);
    end
    cyc++;
  end

  function automatic logic [W-1:0] mk(input logic [EW-1:0] els);
    logic [G-1:0] m;
    for (int i = 0; i < G; i++) m[i] = (els[i*DW +: DW] == '0);
    return {m, els};
  endfunction

  function automatic logic [EW-1:0] rnd_group(input int zpct);
    logic [EW-1:0] e;
    for (int i = 0; i < G; i++)
      e[i*DW +: DW] = ($urandom_range(0, 99) < zpct) ? '0 : DW'($urandom_range(1, 255));
    return e;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_cfg(input int it, input int rd);
    configure = 1'b1;
    num_iters = LI'(it);
    num_reads_per_iter = LR'(rd);
    tick();
    configure = 1'b0;
  endtask

  task automatic push(input logic [W-1:0] w);
    int k = 0;
    while (!avail_out && k < 200) begin tick(); k++; end
    if (!avail_out) check("push_timeout", 0, 1);
    valid_in = 1'b1;
    data_in  = w;
    tick();
    valid_in = 1'b0;
  endtask

  task automatic wait_done(input int d0, input int budget);
    int k = 0;
    while (done_cnt == d0 && k < budget) begin tick(); k++; end
    check("done_seen", done_cnt - d0, 1);
  endtask

  task automatic clear_log();
    log_d.delete(); log_i.delete(); log_l.delete(); log_t.delete();
  endtask

  // One full run with a concurrent producer; pushes exactly the groups the run needs.
  task automatic run(input int it, input int rd, input int zpct, input int mode);
    int n, pushed, d0, nz, k, budget;
    logic [W-1:0] w;
    n = it * rd; pushed = 0; d0 = done_cnt; nz = 0; k = 0;
    budget = n * G * 8 + 200;
    clear_log();
    do_cfg(it, rd);
    while (done_cnt == d0 && k < budget) begin
      avail_in = (mode == 0) ? 1'b1 : (mode == 1) ? ~avail_in : ($urandom_range(0, 3) != 0);
      if (pushed < n && avail_out && $urandom_range(0, 2) != 0) begin
        w = mk(rnd_group(zpct));
        valid_in = 1'b1;
        data_in  = w;
        pushed++;
        nz += G - $countones(w[W-1 -: G]);
      end else begin
        valid_in = 1'b0;
      end
      tick();
      k++;
    end
    valid_in = 1'b0;
    avail_in = 1'b1;
    check("run_done", done_cnt - d0, 1);
    check("run_count", log_d.size(), nz);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int d0, ok, pushed;
    logic [W-1:0] w;
    rst = 1'b0; configure = 1'b0; valid_in = 1'b0; avail_in = 1'b1;
    num_iters = '0; num_reads_per_iter = '0; data_in = '0;

    // Reset state
    tick();
    chk_en = 1'b1;
    tick(); tick();
    check("rst_valid", valid_out, 0);
    check("rst_data", data_out, 0);
    check("rst_index", index_out, 0);
    check("rst_last", last_out, 0);
    check("rst_done", done_out, 0);
    check("rst_avail", avail_out, 1);
    rst = 1'b1;
    tick();

    // Directed single group {05,00,07,00}
    clear_log(); d0 = done_cnt;
    do_cfg(1, 1);
    w = mk({8'h00, 8'h07, 8'h00, 8'h05});
    check("t1_mask", w[W-1 -: G], 4'b1010);
    push(w);
    wait_done(d0, 50);
    check("t1_count", log_d.size(), 2);
    if (log_d.size() == 2) begin
      check("t1_d0", log_d[0], 8'h05);
      check("t1_i0", log_i[0], 0);
      check("t1_l0", log_l[0], 0);
      check("t1_d1", log_d[1], 8'h07);
      check("t1_i1", log_i[1], 2);
      check("t1_l1", log_l[1], 1);
      check("t1_done_lat", done_t - log_t[1], 1);
    end

    // Four dense groups streamed back to back
    clear_log(); d0 = done_cnt;
    do_cfg(2, 2);
    for (int g = 0; g < 4; g++) push(mk(rnd_group(0)));
    wait_done(d0, 100);
    check("t2_count", log_d.size(), 16);
    if (log_d.size() == 16) begin
      check("t2_span", log_t[15] - log_t[0], 15);
      ok = 1;
      for (int i = 0; i < 16; i++) if (log_l[i] != (i % 4 == 3)) ok = 0;
      check("t2_last_pattern", ok, 1);
    end
    tick(); tick();
    check("t2_one_done", done_cnt - d0, 1);

    // All-zero group sandwiched between dense groups
    clear_log(); d0 = done_cnt;
    push(mk(rnd_group(0)));
    push(mk('0));
    push(mk(rnd_group(0)));
    do_cfg(1, 3);
    wait_done(d0, 100);
    check("t3_count", log_d.size(), 8);
    if (log_d.size() == 8) check("t3_gap_ok", (log_t[4] - log_t[3]) <= 2, 1);

    // avail_in toggling every cycle
    run(2, 3, 25, 1);

    // Backpressure: FIFO fills, avail_out drops, nothing is lost
    clear_log(); d0 = done_cnt;
    avail_in = 1'b0;
    do_cfg(1, 4);
    pushed = 0;
    for (int k = 0; k < 10; k++) begin
      if (pushed < 4 && avail_out) begin
        valid_in = 1'b1; data_in = mk(rnd_group(0)); pushed++;
      end else begin
        valid_in = 1'b0;
      end
      tick();
    end
    valid_in = 1'b0;
    check("t5_pushed", pushed, 4);
    check("t5_avail_low", avail_out, 0);
    check("t5_no_emit", log_d.size(), 0);
    avail_in = 1'b1;
    wait_done(d0, 100);
    check("t5_count", log_d.size(), 16);

    // configure with two elements of a group still pending
    clear_log(); d0 = done_cnt;
    do_cfg(1, 1);
    push(mk(rnd_group(0)));
    ok = 0;
    while (log_d.size() < 2 && ok < 50) begin tick(); ok++; end
    avail_in = 1'b0;
    check("t6_two_out", log_d.size(), 2);
    push(mk(rnd_group(0)));
    push(mk(rnd_group(0)));
    do_cfg(1, 2);
    avail_in = 1'b1;
    wait_done(d0, 100);
    check("t6_count", log_d.size(), 10);

    // Randomized runs
    for (int r = 0; r < 6; r++)
      run($urandom_range(1, 3), $urandom_range(1, 3), 40, 2);

    // Zero-count configure starts no run
    clear_log(); d0 = done_cnt;
    push(mk(rnd_group(0)));
    do_cfg(0, 5);
    for (int k = 0; k < 6; k++) tick();
    check("t7_no_emit", log_d.size(), 0);
    check("t7_no_done", done_cnt - d0, 0);

    // Reset mid-run abandons everything
    do_cfg(1, 3);
    push(mk(rnd_group(0)));
    rst = 1'b0;
    tick();
    check("t8_valid", valid_out, 0);
    check("t8_data", data_out, 0);
    check("t8_done", done_out, 0);
    check("t8_avail", avail_out, 1);
    rst = 1'b1;
    clear_log();
    for (int k = 0; k < 4; k++) tick();
    check("t8_quiet", log_d.size(), 0);
    run(1, 2, 30, 0);

    tick(); tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/nonzero_serializer.md
# nonzero_serializer

Consumer of the zero-flagged activation groups produced by the repetition detector. Accepts one group per transfer (GROUP_SIZE elements plus a GROUP_SIZE-bit zero mask in the top bits) and emits only the nonzero elements, one per cycle, lowest index first, each tagged with its in-group index and a last-of-group flag. All-zero groups are consumed without producing output. Group count per run is bounded by the same iteration control (`num_iters` × `num_reads_per_iter`) used upstream.

## Interface
- `GROUP_SIZE`, 4: elements per group; power of two, ≥2
- `LOG_GROUP_SIZE`, 2: log2(GROUP_SIZE)
- `DATA_WIDTH`, 8: element width
- `LOG_MAX_ITERS`, 16: width of `num_iters`
- `LOG_MAX_READS_PER_ITER`, 16: width of `num_reads_per_iter`
- `clk`  in  1  clock; the only clock
- `rst`  in  1  reset; synchronous, active-low
- `configure`  in  1  load counters, start a run
- `num_iters`  in  LOG_MAX_ITERS  iterations per run
- `num_reads_per_iter`  in  LOG_MAX_READS_PER_ITER  groups per iteration
- `data_in`  in  GROUP_SIZE*DATA_WIDTH+GROUP_SIZE  bits [GROUP_SIZE*DATA_WIDTH-1:0] are elements (element i at [i*DATA_WIDTH +: DATA_WIDTH]); top GROUP_SIZE bits are the zero mask (bit i = 1 means element i is zero)
- `valid_in`  in  1  write `data_in` this cycle
- `avail_out`  out  1  may accept input
- `data_out`  out  DATA_WIDTH  nonzero element
- `index_out`  out  LOG_GROUP_SIZE  index of `data_out` within its group
- `last_out`  out  1  final nonzero element of its group
- `valid_out`  out  1  output element valid
- `avail_in`  in  1  downstream may accept
- `done_out`  out  1  one-cycle pulse at end of run

## Operation
- Input: 4-slot FIFO (existing `FIFO`), written whenever `valid_in` = 1. `avail_out` = ~almost_full & ~full. Producer must observe `avail_out`. Overflow is not detected.
- Group register `data_r`. Pending mask `pend_r`: bit i = 1 means element i has not yet been emitted.
- Emit: when `pend_r` ≠ 0 and `avail_in` = 1:
  - `valid_out` = 1, `index_out` = lowest set bit of `pend_r`, `data_out` = that element of `data_r`.
  - That bit of `pend_r` clears.
  - `last_out` = 1 if it was the only set bit.
- Load: when `enabled_r` = 1, FIFO is non-empty, and (`pend_r` = 0 or this cycle is a last-element emit):
  - Pop the FIFO, `data_r` ← elements, `pend_r` ← ~mask.
  - Decrement iteration counters exactly as upstream: on reads = 1, either reload reads from its copy and decrement iters, or, if iters = 1, clear `enabled_r`.
- All-zero group: loads with `pend_r` = 0 and emits nothing. It is counted and takes one cycle.
- `configure` (priority over load/emit): latch counters and copy, `pend_r` ← 0 (any in-flight group is discarded; FIFO contents are kept), `enabled_r` ← 1, `busy_r` ← 1.
- `configure` with `num_iters` = 0 or `num_reads_per_iter` = 0: `enabled_r` and `busy_r` stay 0. No run starts.
- End of run: when `busy_r` = 1, `enabled_r` = 0 and `pend_r` = 0, `done_out` = 1 for that cycle only and `busy_r` ← 0.
- Groups that arrive after the run ends stay in the FIFO until the next `configure`.
- States: IDLE (`busy_r` = 0) → RUN on `configure`. RUN → DRAIN when the last group loads (`enabled_r` = 0, `pend_r` ≠ 0). DRAIN → IDLE with a `done_out` pulse when `pend_r` = 0. If the last group is all-zero, RUN → IDLE directly.

## Timing
- Reset values: `valid_out` = 0, `data_out` = 0, `index_out` = 0, `last_out` = 0, `done_out` = 0, `avail_out` = 1. All counters, `enabled_r`, `busy_r`, `pend_r` and `data_r` = 0.
- Reset mid-run abandons the run. Nothing is emitted until the next `configure`.
- `valid_out`, `data_out`, `index_out`, `last_out` are combinational from `pend_r`, `data_r` and `avail_in`. There are no output registers.
- Latency: a word written in cycle t can load at t+1 at the earliest. Its first element appears at t+2.
- Throughput: one output per cycle while `avail_in` = 1. There is no bubble between groups, because a load overlaps a last-element emit.
- `avail_in` = 0 holds `pend_r` and `data_r`; no load occurs while `pend_r` ≠ 0.
- `done_out` appears one cycle after the final emit, or one cycle after the final load if that group is all-zero.

## Structure
- `RTLinf.vh`: shared defines (debug enable).
- Sub-modules:
  - Reuse `FIFO` for input buffering.
  - One new sub-module, `lsb_priority_encoder` (GROUP_SIZE → index + any-set flag), is natural.
- Iteration-control logic matches the upstream block bit for bit.

## Test plan
- Reset, then configure iters = 1, reads = 1. Group {0x05, 0x00, 0x07, 0x00}, mask 4'b1010 → outputs (5, idx 0), (7, idx 2, last), then `done_out` one cycle later.
- iters = 2, reads = 2. Four dense groups sent back-to-back, `avail_in` = 1 → 16 consecutive valid cycles, `last_out` on every 4th, one `done_out`.
- All-zero group between two dense groups → no output for it. The next group's first element follows the previous `last_out` by at most one cycle, and the group count still decrements.
- Toggle `avail_in` 1/0 every cycle → each element is emitted once, in index order. Outputs hold while `avail_in` = 0.
- Drive `valid_in` every cycle with `avail_in` = 0 → `avail_out` falls once the FIFO reaches almost-full, and no data is lost after `avail_in` returns to 1.
- `configure` mid-group, with 2 elements pending → pending elements are dropped, FIFO groups are processed under the new counts. Also: `rst` low mid-run → all outputs return to reset values.
